// File: rtl/alu_op_pkg.sv
// alu_op_pkg: ALU op encoding, RV32I opcodes, immediate formats and decode bundle
package alu_op_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  typedef struct packed {
    alu_op_t     alu_op;
    logic [4:0]  shamt;
    logic        shamt_reg;
    logic        branch;
    logic [2:0]  branch_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src_imm;
    logic        reg_write;
    logic        illegal;
  } decoded_t;
  function automatic alu_op_t f3_op(input logic [2:0] f3);
    case (f3)
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      3'd7:    return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction
  function automatic logic [31:0] make_imm(input imm_fmt_t f, input logic [31:0] i);
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: fetch-side and execute-side handshake plus decoded bundle
interface id_decode_stage_if;
  import alu_op_pkg::*;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     out_alu_op;
  logic [4:0]  out_shamt;
  logic        out_shamt_reg;
  logic        out_branch;
  logic [2:0]  out_branch_type;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_alu_src_imm;
  logic        out_reg_write;
  logic [31:0] out_pc;
  logic        out_illegal;
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_shamt, out_shamt_reg, out_branch,
           out_branch_type, out_rs1, out_rs2, out_rd, out_imm, out_alu_src_imm,
           out_reg_write, out_pc, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_shamt, out_shamt_reg, out_branch,
           out_branch_type, out_rs1, out_rs2, out_rd, out_imm, out_alu_src_imm,
           out_reg_write, out_pc, out_illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I decode into an execute bundle
module instr_decoder
  import alu_op_pkg::*;
(
  input  logic [31:0] i_instr,
  output decoded_t    o_dec
);
  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  imm_fmt_t   w_fmt;
  alu_op_t    w_op;
  logic       w_src, w_rw, w_br, w_ill, w_sh_imm;
  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  always_comb begin
    w_fmt    = IMM_NONE;
    w_op     = ALU_ADD;
    w_src    = 1'b0;
    w_rw     = 1'b0;
    w_br     = 1'b0;
    w_ill    = 1'b0;
    w_sh_imm = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_rw  = 1'b1;
        w_op  = (w_f7 == F7_ZERO) ? f3_op(w_f3) :
                (w_f7 == F7_ALT && w_f3 == 3'd0) ? ALU_SUB :
                (w_f7 == F7_ALT && w_f3 == 3'd5) ? ALU_SRA : ALU_ADD;
        w_ill = !(w_f7 == F7_ZERO || (w_f7 == F7_ALT && (w_f3 == 3'd0 || w_f3 == 3'd5)));
      end
      OPC_OPIMM: begin
        w_fmt    = IMM_I;
        w_src    = 1'b1;
        w_rw     = 1'b1;
        w_sh_imm = w_f3[1:0] == 2'b01;
        w_op     = (w_f3 == 3'd5 && w_f7 == F7_ALT) ? ALU_SRA : f3_op(w_f3);
        w_ill    = w_sh_imm && !(w_f7 == F7_ZERO || (w_f3 == 3'd5 && w_f7 == F7_ALT));
      end
      OPC_LOAD, OPC_JALR: begin
        w_fmt = IMM_I;
        w_src = 1'b1;
        w_rw  = 1'b1;
      end
      OPC_STORE: begin
        w_fmt = IMM_S;
        w_src = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt = IMM_B;
        w_op  = ALU_SUB;
        w_br  = 1'b1;
        w_ill = w_f3[2:1] == 2'b01;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt = IMM_U;
        w_src = 1'b1;
        w_rw  = 1'b1;
      end
      OPC_JAL: begin
        w_fmt = IMM_J;
        w_src = 1'b1;
        w_rw  = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end
  // an illegal word still travels down the pipe, but with every side effect masked
  assign o_dec.illegal     = w_ill;
  assign o_dec.alu_op      = w_ill ? ALU_ADD : w_op;
  assign o_dec.shamt       = (w_sh_imm && !w_ill) ? i_instr[24:20] : 5'd0;
  assign o_dec.shamt_reg   = w_opc == OPC_OP && !w_ill && (w_op == ALU_SLL || w_op == ALU_SRL || w_op == ALU_SRA);
  assign o_dec.branch      = w_br && !w_ill;
  assign o_dec.branch_type = (w_br && !w_ill) ? w_f3 : 3'd0;
  assign o_dec.rs1         = i_instr[19:15];
  assign o_dec.rs2         = i_instr[24:20];
  assign o_dec.rd          = (w_opc == OPC_BRANCH || w_opc == OPC_STORE) ? 5'd0 : i_instr[11:7];
  assign o_dec.imm         = w_ill ? 32'd0 : make_imm(w_fmt, i_instr);
  assign o_dec.alu_src_imm = w_src && !w_ill;
  assign o_dec.reg_write   = w_rw && !w_ill && i_instr[11:7] != 5'd0;
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: single-entry decode pipeline register with valid/ready handshake and flush
module id_decode_stage
  import alu_op_pkg::*;
(
  input logic clk,
  input logic rst,
  id_decode_stage_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t      r_state, w_next;
  decoded_t    w_dec, r_dec;
  logic [31:0] r_pc;
  logic        w_acc;
  instr_decoder u_dec (.i_instr(bus.in_instr), .o_dec(w_dec));
  assign bus.in_ready = r_state == EMPTY || bus.out_ready;
  assign w_acc = bus.in_valid && bus.in_ready && !bus.flush;
  always_comb begin
    w_next = bus.flush ? EMPTY : w_acc ? FULL : bus.out_ready ? EMPTY : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_dec   <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_dec <= w_dec;
        r_pc  <= bus.in_pc;
      end
    end
  end
  assign bus.out_valid       = r_state == FULL;
  assign bus.out_alu_op      = r_dec.alu_op;
  assign bus.out_shamt       = r_dec.shamt;
  assign bus.out_shamt_reg   = r_dec.shamt_reg;
  assign bus.out_branch      = r_dec.branch;
  assign bus.out_branch_type = r_dec.branch_type;
  assign bus.out_rs1         = r_dec.rs1;
  assign bus.out_rs2         = r_dec.rs2;
  assign bus.out_rd          = r_dec.rd;
  assign bus.out_imm         = r_dec.imm;
  assign bus.out_alu_src_imm = r_dec.alu_src_imm;
  assign bus.out_reg_write   = r_dec.reg_write;
  assign bus.out_pc          = r_pc;
  assign bus.out_illegal     = r_dec.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed vectors checked by a mnemonic-level decode model and literal pins
module tb_id_decode_stage;
  import alu_op_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  id_decode_stage_if bus ();
  id_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  function automatic decoded_t model(input logic [31:0] x);
    decoded_t d;
    alu_op_t tab [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ill;
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = x[6:0];
    f3 = x[14:12];
    f7 = x[31:25];
    d = '0;
    ill = 1'b1;
    d.rs1 = x[19:15];
    d.rs2 = x[24:20];
    d.rd = (op == 7'h63 || op == 7'h23) ? 5'd0 : x[11:7];
    case (op)
      7'h33: begin
        if (f7 == 7'h00) begin d.alu_op = tab[f3]; ill = 1'b0; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin d.alu_op = ALU_SUB; ill = 1'b0; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin d.alu_op = ALU_SRA; ill = 1'b0; end
        if (!ill) begin
          d.reg_write = 1'b1;
          d.shamt_reg = (f3 == 3'd1 || f3 == 3'd5);
        end
      end
      7'h13: begin
        if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
          ill = 1'b0;
          d.alu_op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tab[f3];
          d.imm = {{20{x[31]}}, x[31:20]};
          d.alu_src_imm = 1'b1;
          d.reg_write = 1'b1;
          d.shamt = (f3 == 3'd1 || f3 == 3'd5) ? x[24:20] : 5'd0;
        end
      end
      7'h03, 7'h67: begin
        ill = 1'b0;
        d.imm = {{20{x[31]}}, x[31:20]};
        d.alu_src_imm = 1'b1;
        d.reg_write = 1'b1;
      end
      7'h23: begin
        ill = 1'b0;
        d.imm = {{20{x[31]}}, x[31:25], x[11:7]};
        d.alu_src_imm = 1'b1;
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        ill = 1'b0;
        d.alu_op = ALU_SUB;
        d.branch = 1'b1;
        d.branch_type = f3;
        d.imm = {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        ill = 1'b0;
        d.imm = {x[31:12], 12'h000};
        d.alu_src_imm = 1'b1;
        d.reg_write = 1'b1;
      end
      7'h6f: begin
        ill = 1'b0;
        d.imm = {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
        d.alu_src_imm = 1'b1;
        d.reg_write = 1'b1;
      end
      default: ;
    endcase
    d.illegal = ill;
    if (x[11:7] == 5'd0) d.reg_write = 1'b0;
    return d;
  endfunction
  logic        m_valid = 1'b0;
  decoded_t    m_d = '0;
  logic [31:0] m_pc = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_d = '0;
      m_pc = '0;
    end else if (bus.flush) m_valid = 1'b0;
    else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid = 1'b1;
      m_d = model(bus.in_instr);
      m_pc = bus.in_pc;
    end else if (bus.out_ready) m_valid = 1'b0;
  end
  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_valid);
    chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
    if (m_valid) begin
      chk("alu_op", bus.out_alu_op, m_d.alu_op);
      chk("shamt", bus.out_shamt, m_d.shamt);
      chk("shamt_reg", bus.out_shamt_reg, m_d.shamt_reg);
      chk("branch", bus.out_branch, m_d.branch);
      chk("branch_type", bus.out_branch_type, m_d.branch_type);
      chk("rs1", bus.out_rs1, m_d.rs1);
      chk("rs2", bus.out_rs2, m_d.rs2);
      chk("rd", bus.out_rd, m_d.rd);
      chk("imm", bus.out_imm, m_d.imm);
      chk("alu_src_imm", bus.out_alu_src_imm, m_d.alu_src_imm);
      chk("reg_write", bus.out_reg_write, m_d.reg_write);
      chk("illegal", bus.out_illegal, m_d.illegal);
      chk("pc", bus.out_pc, m_pc);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc = pc;
    step();
    bus.in_valid = 1'b0;
  endtask
  logic [31:0] vec [21] = '{
    32'h402081B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020A1B3, 32'h0020B1B3,
    32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h002091B3, 32'h020081B3,
    32'h00109093, 32'h02009093, 32'h0000A183, 32'hFE112E23, 32'h123452B7,
    32'h00000097, 32'h008000EF, 32'h000080E7, 32'h0020A463, 32'h00000033,
    32'h0000000F
  };
  logic [31:0] strm [4] = '{32'h00308133, 32'h00A00293, 32'h00112223, 32'hFE000EE3};
  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_alu_op", bus.out_alu_op, ALU_ADD);
    chk("rst_imm", bus.out_imm, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    rst = 1'b0;
    put(32'h002081B3, 32'h100);
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_op", bus.out_alu_op, ALU_ADD);
    chk("add_rs1", bus.out_rs1, 5'd1);
    chk("add_rs2", bus.out_rs2, 5'd2);
    chk("add_rd", bus.out_rd, 5'd3);
    chk("add_rw", bus.out_reg_write, 1'b1);
    chk("add_src", bus.out_alu_src_imm, 1'b0);
    chk("add_pc", bus.out_pc, 32'h100);
    put(32'h40735293, 32'h104);
    chk("srai_op", bus.out_alu_op, ALU_SRA);
    chk("srai_shamt", bus.out_shamt, 5'd7);
    chk("srai_shreg", bus.out_shamt_reg, 1'b0);
    chk("srai_src", bus.out_alu_src_imm, 1'b1);
    chk("srai_rd", bus.out_rd, 5'd5);
    put(32'hFFF00093, 32'h108);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_rd", bus.out_rd, 5'd1);
    put(32'h00208463, 32'h10C);
    chk("beq_branch", bus.out_branch, 1'b1);
    chk("beq_type", bus.out_branch_type, 3'd0);
    chk("beq_imm", bus.out_imm, 32'd8);
    chk("beq_rd", bus.out_rd, 5'd0);
    chk("beq_rw", bus.out_reg_write, 1'b0);
    chk("beq_op", bus.out_alu_op, ALU_SUB);
    put(32'h0020E463, 32'h110);
    chk("bltu_type", bus.out_branch_type, 3'd6);
    put(32'hFFFFFFFF, 32'h114);
    chk("ill_valid", bus.out_valid, 1'b1);
    chk("ill_flag", bus.out_illegal, 1'b1);
    chk("ill_rw", bus.out_reg_write, 1'b0);
    for (int i = 0; i < 21; i++) put(vec[i], 32'h120 + 32'(4 * i));
    put(32'h002081B3, 32'h200);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = strm[0];
    bus.in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_pc", bus.out_pc, 32'h200);
      chk("stall_rd", bus.out_rd, 5'd3);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_instr = strm[i];
      bus.in_pc = 32'h204 + 32'(4 * i);
      step();
      chk("stream_valid", bus.out_valid, 1'b1);
      chk("stream_pc", bus.out_pc, 32'h204 + 32'(4 * i));
    end
    bus.in_valid = 1'b0;
    step();
    chk("drain_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    put(32'h00A00293, 32'h300);
    chk("pre_flush_valid", bus.out_valid, 1'b1);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h002081B3;
    bus.in_pc = 32'h304;
    step();
    chk("flush_valid", bus.out_valid, 1'b0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("flush_no_accept", bus.out_valid, 1'b0);
    put(32'h002081B3, 32'h400);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_full_valid", bus.out_valid, 1'b0);
    chk("rst_full_rs1", bus.out_rs1, 5'd0);
    chk("rst_full_rd", bus.out_rd, 5'd0);
    chk("rst_full_rw", bus.out_reg_write, 1'b0);
    chk("rst_full_pc", bus.out_pc, 32'd0);
    chk("rst_full_op", bus.out_alu_op, ALU_ADD);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
